// File: rtl/vga_capture_scaler_if.sv
// Camera-side stream and frame-buffer write bus of the capture scaler.
// The master modport drives camera and control inputs; the scaler is the slave.
interface vga_capture_scaler_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  enable;
  logic                  mode;
  logic                  h_ref;
  logic                  v_sync;
  logic [7:0]            data_in;
  logic [7:0]            pix_out;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  we;
  logic                  frame_start;
  logic                  frame_done;
  logic                  overflow;

  modport master (
    output enable, mode, h_ref, v_sync, data_in,
    input  pix_out, write_addr, we, frame_start, frame_done, overflow
  );

  modport slave (
    input  enable, mode, h_ref, v_sync, data_in,
    output pix_out, write_addr, we, frame_start, frame_done, overflow
  );
endinterface

// File: rtl/vga_capture_scaler.sv
// Camera capture front-end: extracts Y from the pixel-byte stream, reduces it
// by decimation or horizontal box averaging, and writes it to the frame buffer.
module vga_capture_scaler #(
  parameter int ADDR_WIDTH  = 15,
  parameter int H_DECIM     = 4,
  parameter int V_DECIM     = 4,
  parameter int BYTE_STRIDE = 2,
  parameter int Y_OFFSET    = 1,
  parameter int MAX_PIXELS  = 19200
) (
  input  logic                  pclk,
  input  logic                  reset,
  vga_capture_scaler_if.slave   bus
);

  localparam int HL    = $clog2(H_DECIM);
  localparam int PW    = (HL > 0) ? HL : 1;
  localparam int RW    = (V_DECIM > 1) ? $clog2(V_DECIM) : 1;
  localparam int BW    = (BYTE_STRIDE > 1) ? $clog2(BYTE_STRIDE) : 1;
  localparam int ACC_W = 8 + HL;
  localparam int PTR_W = ADDR_WIDTH + 1;

  localparam logic [PW-1:0]    PIX_LAST  = PW'(H_DECIM - 1);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(V_DECIM - 1);
  localparam logic [BW-1:0]    BYTE_LAST = BW'(BYTE_STRIDE - 1);
  localparam logic [BW-1:0]    Y_OFF     = BW'(Y_OFFSET);
  localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(MAX_PIXELS);

  // Group sum never exceeds ACC_W bits, so the shift is a plain truncating mean.
  function automatic logic [7:0] avg_trunc(input logic [ACC_W-1:0] sum);
    avg_trunc = 8'(sum >> HL);
  endfunction

  logic              v_sync_q, v_sync_d;
  logic              h_ref_q, h_ref_d;
  logic              active_q, active_d;
  logic              mode_q, mode_d;
  logic [RW-1:0]     row_q, row_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wrote_q, wrote_d;
  logic [7:0]        pix_out_q, pix_out_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              fs_q, fs_d;
  logic              fd_q, fd_d;
  logic              ovf_q, ovf_d;

  logic              v_edge, line_end, sample, wr;
  logic [7:0]        val;
  logic [ACC_W-1:0]  sum;

  assign v_edge   = bus.v_sync & ~v_sync_q;
  assign line_end = h_ref_q & ~bus.h_ref;
  assign sample   = bus.h_ref & ~v_edge & active_q & (row_q == '0) & (byte_q == Y_OFF);
  assign sum      = acc_q + ACC_W'(bus.data_in);

  always_comb begin
    v_sync_d  = bus.v_sync;
    h_ref_d   = bus.h_ref;
    active_d  = active_q;
    mode_d    = mode_q;
    row_d     = row_q;
    byte_d    = byte_q;
    pix_d     = pix_q;
    acc_d     = acc_q;
    ptr_d     = ptr_q;
    wrote_d   = wrote_q;
    pix_out_d = pix_out_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q;
    we_d      = 1'b0;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    wr        = 1'b0;
    val       = bus.data_in;

    if (v_edge) begin
      // A byte arriving on the frame-start cycle is dropped along with all counters.
      fd_d     = active_q & wrote_q;
      active_d = bus.enable;
      mode_d   = bus.mode;
      fs_d     = bus.enable;
      row_d    = '0;
      byte_d   = '0;
      pix_d    = '0;
      acc_d    = '0;
      ptr_d    = '0;
      wrote_d  = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (line_end) begin
        row_d  = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        byte_d = '0;
        pix_d  = '0;
        acc_d  = '0;
      end
      if (bus.h_ref) begin
        byte_d = (byte_q == BYTE_LAST) ? '0 : byte_q + 1'b1;
      end
      if (sample) begin
        pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
        if (mode_q) begin
          if (pix_q == PIX_LAST) begin
            wr    = 1'b1;
            val   = avg_trunc(sum);
            acc_d = '0;
          end else begin
            acc_d = sum;
          end
        end else if (pix_q == '0) begin
          wr = 1'b1;
        end
      end
      if (wr) begin
        if (ptr_q == PTR_FULL) begin
          ovf_d = 1'b1;
        end else begin
          we_d      = 1'b1;
          pix_out_d = val;
          addr_d    = ptr_q[ADDR_WIDTH-1:0];
          ptr_d     = ptr_q + 1'b1;
          wrote_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      v_sync_q  <= 1'b1;
      h_ref_q   <= 1'b0;
      active_q  <= 1'b0;
      mode_q    <= 1'b0;
      row_q     <= '0;
      byte_q    <= '0;
      pix_q     <= '0;
      acc_q     <= '0;
      ptr_q     <= '0;
      wrote_q   <= 1'b0;
      pix_out_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      v_sync_q  <= v_sync_d;
      h_ref_q   <= h_ref_d;
      active_q  <= active_d;
      mode_q    <= mode_d;
      row_q     <= row_d;
      byte_q    <= byte_d;
      pix_q     <= pix_d;
      acc_q     <= acc_d;
      ptr_q     <= ptr_d;
      wrote_q   <= wrote_d;
      pix_out_q <= pix_out_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.pix_out     = pix_out_q;
  assign bus.write_addr  = addr_q;
  assign bus.we          = we_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_vga_capture_scaler.sv
// Bench for vga_capture_scaler: a line-level reference model feeds a queue of
// expected writes, and a table of Y patterns checks both reduction modes.
module tb_vga_capture_scaler;
  localparam int AW = 6, HD = 4, VD = 2, BS = 2, YO = 1, MAXP = 40;

  logic pclk  = 1'b0;
  logic reset = 1'b1;
  always #5 pclk = ~pclk;

  vga_capture_scaler_if #(.ADDR_WIDTH(AW)) bus();

  vga_capture_scaler #(
    .ADDR_WIDTH(AW), .H_DECIM(HD), .V_DECIM(VD),
    .BYTE_STRIDE(BS), .Y_OFFSET(YO), .MAX_PIXELS(MAXP)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    pix;
  } exp_t;

  typedef struct {
    bit         md;
    logic [7:0] y[4];
    logic [7:0] exp;
  } vec_t;

  exp_t       q[$];
  int         wlog[$];
  vec_t       tbl[6];
  logic [7:0] lb[64];
  int         lbn;
  int         errors = 0, checks = 0;
  int         fs_cnt = 0;
  int         m_ptr = 0, m_row = 0, m_fw = 0;
  bit         m_act = 0, m_mode = 0, m_ovf = 0;
  int         snap;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge pclk);
    @(negedge pclk);
    if (bus.frame_start) fs_cnt++;
    if (bus.we) begin
      wlog.push_back(int'(bus.pix_out));
      if (q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = q.pop_front();
        chk("write_addr", int'(bus.write_addr), int'(e.addr));
        chk("pix_out", int'(bus.pix_out), int'(e.pix));
      end
    end
  endtask

  task automatic push_exp(input logic [7:0] v);
    exp_t t;
    if (m_ptr == MAXP) begin
      m_ovf = 1'b1;
    end else begin
      t.addr = AW'(m_ptr);
      t.pix  = v;
      q.push_back(t);
      m_ptr++;
      m_fw++;
    end
  endtask

  task automatic model_line();
    int y[64];
    int ny, sum;
    if (m_act && m_row == 0) begin
      ny = 0;
      for (int idx = YO; idx < lbn; idx += BS) begin
        y[ny] = int'(lb[idx]);
        ny++;
      end
      for (int g = 0; (g + 1) * HD <= ny; g++) begin
        if (m_mode) begin
          sum = 0;
          for (int j = 0; j < HD; j++) sum += y[g*HD + j];
          push_exp(8'(sum / HD));
        end else begin
          push_exp(8'(y[g*HD]));
        end
      end
    end
  endtask

  task automatic drive_line(input bit use_model, input bit finish);
    if (use_model) model_line();
    for (int i = 0; i < lbn; i++) begin
      bus.h_ref   = 1'b1;
      bus.data_in = lb[i];
      step();
    end
    if (finish) begin
      bus.h_ref = 1'b0;
      repeat (4) step();
      m_row = (m_row + 1) % VD;
    end
  endtask

  task automatic fill_rand(input int n);
    lbn = n;
    for (int i = 0; i < n; i++) lb[i] = 8'($urandom_range(1, 255));
  endtask

  task automatic vsync(input bit en, input bit md);
    bit exp_fd;
    exp_fd     = m_act && (m_fw > 0);
    bus.v_sync = 1'b1;
    bus.enable = en;
    bus.mode   = md;
    step();
    chk("frame_start", int'(bus.frame_start), int'(en));
    chk("frame_done", int'(bus.frame_done), int'(exp_fd));
    chk("overflow_cleared", int'(bus.overflow), 0);
    bus.v_sync = 1'b0;
    m_act = en; m_mode = md; m_ptr = 0; m_fw = 0; m_row = 0; m_ovf = 0;
    step();
    chk("frame_start_one_cycle", int'(bus.frame_start), 0);
    step();
  endtask

  task automatic set_vec(input int i, input bit md, input logic [7:0] a, b, c, d, e);
    tbl[i].md   = md;
    tbl[i].y[0] = a; tbl[i].y[1] = b; tbl[i].y[2] = c; tbl[i].y[3] = d;
    tbl[i].exp  = e;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"}, int'(bus.we), 0);
    chk({tag, "_pix_out"}, int'(bus.pix_out), 0);
    chk({tag, "_write_addr"}, int'(bus.write_addr), 0);
    chk({tag, "_frame_start"}, int'(bus.frame_start), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_vec(0, 1'b1, 8'd10,  8'd20,  8'd30,  8'd40,  8'd25);
    set_vec(1, 1'b1, 8'd255, 8'd255, 8'd255, 8'd254, 8'd254);
    set_vec(2, 1'b1, 8'd0,   8'd0,   8'd0,   8'd3,   8'd0);
    set_vec(3, 1'b1, 8'd1,   8'd2,   8'd3,   8'd4,   8'd2);
    set_vec(4, 1'b0, 8'd77,  8'd1,   8'd2,   8'd3,   8'd77);
    set_vec(5, 1'b0, 8'd255, 8'd0,   8'd0,   8'd0,   8'd255);

    bus.v_sync = 1'b1; bus.enable = 1'b1; bus.mode = 1'b0;
    bus.h_ref = 1'b0;  bus.data_in = 8'd0;
    #12;
    chk_outputs_zero("reset");
    @(negedge pclk);
    reset = 1'b0;
    repeat (3) step();
    chk("no_start_with_vsync_high", fs_cnt, 0);
    bus.v_sync = 1'b0;
    step();

    // Decimate frame with byte-index data.
    vsync(1'b1, 1'b0);
    wlog.delete();
    lbn = 32;
    for (int i = 0; i < 32; i++) lb[i] = 8'(i);
    repeat (8) drive_line(1'b1, 1'b1);
    chk("decim_writes", wlog.size(), 16);
    chk("decim_pix0", wlog[0], 1);
    chk("decim_pix1", wlog[1], 9);
    chk("decim_pix2", wlog[2], 17);
    chk("decim_pix3", wlog[3], 25);
    chk("decim_no_overflow", int'(bus.overflow), 0);

    // Table of Y patterns, one captured line per frame.
    for (int i = 0; i < 6; i++) begin
      vsync(1'b1, tbl[i].md);
      lbn = 32;
      for (int p = 0; p < 16; p++) begin
        lb[2*p]     = 8'($urandom_range(0, 255));
        lb[2*p + 1] = tbl[i].y[p % 4];
      end
      for (int g = 0; g < 4; g++) push_exp(tbl[i].exp);
      drive_line(1'b0, 1'b1);
      chk("table_drain", q.size(), 0);
    end

    // Overflow: more eligible lines than the buffer holds.
    vsync(1'b1, 1'b0);
    wlog.delete();
    for (int l = 0; l < 24; l++) begin
      fill_rand(32);
      drive_line(1'b1, 1'b1);
    end
    chk("ovf_writes", wlog.size(), MAXP);
    chk("ovf_flag", int'(bus.overflow), int'(m_ovf));

    // Disabled frame, enable raised mid-frame.
    vsync(1'b0, 1'b0);
    wlog.delete();
    snap = fs_cnt;
    bus.enable = 1'b1;
    for (int l = 0; l < 4; l++) begin
      fill_rand(32);
      drive_line(1'b1, 1'b1);
    end
    chk("disabled_writes", wlog.size(), 0);
    chk("disabled_frame_start", fs_cnt - snap, 0);
    vsync(1'b1, 1'b0);
    for (int l = 0; l < 4; l++) begin
      fill_rand(32);
      drive_line(1'b1, 1'b1);
    end
    chk("reenabled_writes", wlog.size(), 8);

    // Average mode, 6-pixel line: one full group, partial group dropped.
    vsync(1'b1, 1'b1);
    wlog.delete();
    fill_rand(12);
    drive_line(1'b1, 1'b1);
    chk("partial_group_writes", wlog.size(), 1);

    // Frame start coincident with a qualifying Y byte: that byte is dropped.
    vsync(1'b1, 1'b0);
    wlog.delete();
    bus.h_ref = 1'b1; bus.data_in = 8'h11;
    step();
    bus.v_sync = 1'b1; bus.data_in = 8'hAA;
    step();
    chk("coincident_frame_start", int'(bus.frame_start), 1);
    chk("coincident_frame_done", int'(bus.frame_done), 0);
    bus.v_sync = 1'b0; bus.h_ref = 1'b0;
    repeat (4) step();
    chk("coincident_writes", wlog.size(), 0);
    m_act = 1'b1; m_mode = 1'b0; m_ptr = 0; m_fw = 0; m_row = 1; m_ovf = 0;
    for (int l = 0; l < 2; l++) begin
      fill_rand(32);
      drive_line(1'b1, 1'b1);
    end
    chk("coincident_next_rows", wlog.size(), 4);

    // Reset asserted mid-line during an active frame.
    vsync(1'b1, 1'b0);
    fill_rand(16);
    drive_line(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk_outputs_zero("midline_reset");
    q.delete();
    wlog.delete();
    m_act = 1'b0; m_ptr = 0; m_fw = 0; m_row = 0; m_ovf = 0;
    @(negedge pclk);
    reset = 1'b0;
    fill_rand(16);
    drive_line(1'b1, 1'b1);
    fill_rand(32);
    drive_line(1'b1, 1'b1);
    chk("post_reset_writes", wlog.size(), 0);
    vsync(1'b1, 1'b0);
    fill_rand(32);
    drive_line(1'b1, 1'b1);
    chk("post_reset_frame_writes", wlog.size(), 4);

    repeat (4) step();
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
